// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH_IN = 8;

  // One restoring iteration per dividend bit.
  function automatic int iter_count(input int width_in);
    return 2 * width_in;
  endfunction

  localparam int DEF_ITERS = iter_count(DEF_WIDTH_IN);

endpackage

// File: rtl/seq_divider_div_step.sv
// Single restoring-division iteration: shift in one dividend bit, compare, conditionally subtract.
module div_step #(
  parameter int width_in = 8
) (
  input  logic [width_in-1:0] rem_in,
  input  logic                bit_in,
  input  logic [width_in-1:0] divisor,
  output logic [width_in-1:0] rem_out,
  output logic                q_bit
);

  logic [width_in:0] partial;

  always_comb begin
    partial = {rem_in, bit_in};
    q_bit   = (partial >= {1'b0, divisor});
    // The difference is below the divisor whenever q_bit is set, so the low bits are exact.
    rem_out = q_bit ? (partial[width_in-1:0] - divisor) : partial[width_in-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, 2*width_in-bit dividend by width_in-bit divisor, one bit per clock.
// Optional divide-by-zero shortcut and div_zero flag: define SEQ_DIV_ZERO_CHK_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int width_in = DEF_WIDTH_IN
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  start,
  input  logic [2*width_in-1:0] dividend,
  input  logic [width_in-1:0]   divisor,
  output logic                  busy,
  output logic                  done,
  output logic [2*width_in-1:0] quotient,
  output logic [width_in-1:0]   remainder
`ifdef SEQ_DIV_ZERO_CHK_EN
  ,
  output logic                  div_zero
`endif
);

  localparam int QW    = 2 * width_in;
  localparam int ITERS = iter_count(width_in);
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [width_in-1:0]  rem_q, rem_d;
  logic [QW-1:0]        dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [width_in-1:0]  dvs_q, dvs_d;
  logic [QW-1:0]        quo_q, quo_d;
  logic [width_in-1:0]  rmd_q, rmd_d;
  logic [width_in-1:0]  step_rem;
  logic                 step_q;

  div_step #(.width_in(width_in)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[QW-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

`ifdef SEQ_DIV_ZERO_CHK_EN
  logic dz_q, dz_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = '0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[QW-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          quo_d   = {dvd_q[QW-2:0], step_q};
          rmd_d   = step_rem;
        end
`ifdef SEQ_DIV_ZERO_CHK_EN
        if (dvs_q == '0) begin
          state_d = ST_DONE;
          quo_d   = '1;
          rmd_d   = '0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SEQ_DIV_ZERO_CHK_EN
  // The flag is refreshed on every completion, so a good result clears it.
  always_comb begin
    dz_d = dz_q;
    if (state_q == ST_RUN && state_d == ST_DONE) dz_d = (dvs_q == '0);
  end
`endif

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
`ifdef SEQ_DIV_ZERO_CHK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
`ifdef SEQ_DIV_ZERO_CHK_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
`ifdef SEQ_DIV_ZERO_CHK_EN
  assign div_zero  = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of arithmetic expectations, one task per scenario.
module tb_seq_divider;

  localparam int W  = 8;
  localparam int QW = 2 * W;

  logic          clk = 1'b0;
  logic          aclr_n = 1'b1;
  logic          start = 1'b0;
  logic [QW-1:0] dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy, done;
  logic [QW-1:0] quotient;
  logic [W-1:0]  remainder;
`ifdef SEQ_DIV_ZERO_CHK_EN
  logic          div_zero;
`endif

  seq_divider #(.width_in(W)) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SEQ_DIV_ZERO_CHK_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [QW-1:0] q;
    logic [W-1:0]  r;
    logic          dz;
    int            lat;   // edge index (sampling edge = 0) whose pre-edge view first shows done
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t model(input logic [QW-1:0] dvd, input logic [W-1:0] dvs);
    exp_t e;
    if (dvs != 0) begin
      e.q   = dvd / dvs;
      e.r   = W'(dvd % dvs);
      e.dz  = 1'b0;
      e.lat = 17;
    end else begin
      e.q   = '1;
`ifdef SEQ_DIV_ZERO_CHK_EN
      e.r   = '0;
      e.dz  = 1'b1;
      e.lat = 2;
`else
      e.r   = dvd[W-1:0];
      e.dz  = 1'b0;
      e.lat = 17;
`endif
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single sampling edge, then scramble the operand inputs.
  task automatic launch(input logic [QW-1:0] dvd, input logic [W-1:0] dvs);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    sb.push_back(model(dvd, dvs));
    tick();
    start    = 1'b0;
    dividend = QW'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic run_op(input string name, input logic [QW-1:0] dvd, input logic [W-1:0] dvs);
    exp_t          e;
    int            seen;
    int            busy_bad;
    bit            got;
    logic [QW-1:0] q_obs;
    logic [W-1:0]  r_obs;
    launch(dvd, dvs);
    seen = 1;
    busy_bad = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        if (busy !== 1'b1) busy_bad++;
        tick();
        seen++;
      end
    end
    e = sb.pop_front();
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s timeout: done not seen within 40 cycles, expected at edge %0d", name, e.lat);
      return;
    end
    q_obs = quotient;
    r_obs = remainder;
    n_cmp++;
    if (seen !== e.lat) begin
      n_bad++;
      $display("FAIL %s latency: done at edge %0d, expected edge %0d", name, seen, e.lat);
    end
    n_cmp++;
    if (q_obs !== e.q || r_obs !== e.r || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s result: q=%0d r=%0d busy=%b, expected q=%0d r=%0d busy=0 (dvd=%0d dvs=%0d)",
               name, q_obs, r_obs, busy, e.q, e.r, dvd, dvs);
    end
`ifdef SEQ_DIV_ZERO_CHK_EN
    n_cmp++;
    if (div_zero !== e.dz) begin
      n_bad++;
      $display("FAIL %s div_zero: got %b, expected %b", name, div_zero, e.dz);
    end
`endif
    n_cmp++;
    if (busy_bad != 0) begin
      n_bad++;
      $display("FAIL %s busy: low in %0d iterating cycles, expected 0", name, busy_bad);
    end
    if (dvs != 0) begin
      n_cmp++;
      if (({16'b0, q_obs} * dvs + r_obs) != {16'b0, dvd} || r_obs >= dvs) begin
        n_bad++;
        $display("FAIL %s identity: q*d+r=%0d r=%0d, expected %0d with r<%0d",
                 name, {16'b0, q_obs} * dvs + r_obs, r_obs, dvd, dvs);
      end
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || quotient !== q_obs || remainder !== r_obs) begin
      n_bad++;
      $display("FAIL %s hold: done=%b q=%0d r=%0d, expected done=0 q=%0d r=%0d",
               name, done, quotient, remainder, q_obs, r_obs);
    end
  endtask

  task automatic check_cleared(input string name);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      n_bad++;
      $display("FAIL %s: busy=%b done=%b q=%0d r=%0d, expected all 0", name, busy, done, quotient, remainder);
    end
`ifdef SEQ_DIV_ZERO_CHK_EN
    n_cmp++;
    if (div_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL %s div_zero: got %b, expected 0", name, div_zero);
    end
`endif
  endtask

  task automatic test_reset();
    #2 aclr_n = 1'b0;
    #1 check_cleared("reset_async");
    repeat (3) tick();
    check_cleared("reset_held");
    aclr_n = 1'b1;
    tick();
    check_cleared("reset_released");
  endtask

  task automatic test_basic();
    run_op("div_1000_7", 16'd1000, 8'd7);
    run_op("div_ffff_ff", 16'hFFFF, 8'hFF);
    run_op("div_5_9", 16'd5, 8'd9);
    run_op("div_0_1", 16'd0, 8'd1);
    run_op("div_ffff_1", 16'hFFFF, 8'd1);
    run_op("div_fffe_80", 16'hFFFE, 8'h80);
  endtask

  task automatic test_back_to_back();
    logic [QW-1:0] dvds[3] = '{16'd1000, 16'hFFFF, 16'd12345};
    logic [W-1:0]  dvss[3] = '{8'd7, 8'hFF, 8'd123};
    exp_t          e;
    int            seen, last, ndone, nxt;
    dividend = dvds[0];
    divisor  = dvss[0];
    start    = 1'b1;
    sb.push_back(model(dvds[0], dvss[0]));
    nxt = 1;
    tick();
    seen = 1;
    last = 0;
    ndone = 0;
    for (int i = 0; i < 80 && ndone < 3; i++) begin
      if (done === 1'b1) begin
        e = sb.pop_front();
        n_cmp++;
        if (quotient !== e.q || remainder !== e.r) begin
          n_bad++;
          $display("FAIL b2b_result%0d: q=%0d r=%0d, expected q=%0d r=%0d", ndone, quotient, remainder, e.q, e.r);
        end
        n_cmp++;
        if (seen - last !== 17) begin
          n_bad++;
          $display("FAIL b2b_spacing%0d: %0d cycles, expected 17", ndone, seen - last);
        end
        last = seen;
        ndone++;
        if (nxt < 3) begin
          dividend = dvds[nxt];
          divisor  = dvss[nxt];
          sb.push_back(model(dvds[nxt], dvss[nxt]));
          nxt++;
        end else begin
          start = 1'b0;
        end
      end else begin
        // start stays high with junk operands while busy; the DUT must ignore it
        dividend = QW'($urandom);
        divisor  = W'($urandom_range(1, 3));
      end
      tick();
      seen++;
    end
    start = 1'b0;
    n_cmp++;
    if (ndone != 3) begin
      n_bad++;
      $display("FAIL b2b_count: %0d completions, expected 3", ndone);
    end
    sb.delete();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int spurious;
    launch(16'd1000, 8'd7);
    repeat (7) tick();
    #2 aclr_n = 1'b0;
    #1 check_cleared("reset_mid_async");
    void'(sb.pop_front());
    spurious = 0;
    repeat (3) begin
      tick();
      if (done !== 1'b0) spurious++;
    end
    aclr_n = 1'b1;
    repeat (20) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    n_cmp++;
    if (spurious != 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: %0d cycles with done/busy high, expected 0", spurious);
    end
    run_op("div_100_10", 16'd100, 8'd10);
  endtask

  task automatic test_div_zero();
    run_op("div_zero", 16'h1234, 8'd0);
    run_op("after_div_zero", 16'd200, 8'd3);
  endtask

  task automatic test_random();
    logic [W-1:0] dvs;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0:       dvs = W'($urandom_range(0, 3));
        1:       dvs = W'($urandom_range(200, 255));
        default: dvs = W'($urandom);
      endcase
      run_op("random", QW'($urandom), dvs);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_div_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
